ram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port `ram_simple` memory (`we`/`addr`/`data_in`/`data_out`, synchronous write, registered read). It accepts read/write commands from two independent masters, selects one per access with round-robin fairness, and drives the RAM port. Read data is returned to the winning master with a valid strobe. It sits directly in front of `ram_simple`; the masters never touch the RAM port.

---
 rtl/ram_arbiter_pkg.sv | 14 +
 rtl/ram_arbiter_rr_pick2.sv | 14 +
 rtl/ram_arbiter.sv | 102 ++++++++++
 tb/tb_ram_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter shared types: FSM state encoding
// and port index constants.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic PORT_0 = 1'b0;
  localparam logic PORT_1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick.
// On a tie the port not granted last wins.
module rr_pick2 (
  input  logic req_0,
  input  logic req_1,
  input  logic last,
  output logic win,
  output logic any
);

  assign any = req_0 | req_1;
  assign win = (req_0 & req_1) ? ~last : req_1;

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master round-robin sequencer
// in front of a single-port RAM with registered read.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_0,
  input  logic                  req_1,
  input  logic                  we_0,
  input  logic                  we_1,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  output logic                  gnt_0,
  output logic                  gnt_1,
  output logic                  rvalid_0,
  output logic                  rvalid_1,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic pick_win;
  logic pick_any;

  rr_pick2 u_pick (
    .req_0 (req_0),
    .req_1 (req_1),
    .last  (last_q),
    .win   (pick_win),
    .any   (pick_any)
  );

  // State, last-granted pointer and command registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= PORT_1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state; the winner's command is latched on entry to CMD
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = CMD;
          last_d  = pick_win;
          we_d    = pick_win ? we_1 : we_0;
          addr_d  = pick_win ? addr_1 : addr_0;
          wdata_d = pick_win ? wdata_1 : wdata_0;
        end
      end
      CMD:     state_d = we_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decoded from registered state only
  always_comb begin
    gnt_0    = (state_q == CMD) && (last_q == PORT_0);
    gnt_1    = (state_q == CMD) && (last_q == PORT_1);
    rvalid_0 = (state_q == RESP) && (last_q == PORT_0);
    rvalid_1 = (state_q == RESP) && (last_q == PORT_1);
    ram_we   = (state_q == CMD) && we_q;
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign rdata_0   = ram_rdata;
  assign rdata_1   = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized scoreboard bench with
// a behavioural RAM and a shadow-memory reference.
module tb_ram_arbiter;

  typedef struct packed {
    logic       we;
    logic [7:0] a;
    logic [7:0] d;
  } cmd_t;

  typedef struct {
    int         p;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic req [2];
  logic we [2];
  logic [7:0] addr [2];
  logic [7:0] wdata [2];
  logic gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [7:0] rdata_0, rdata_1;
  logic ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  logic [7:0] mem [256];
  logic [7:0] shadow [256];

  cmd_t iss0 [$];
  cmd_t iss1 [$];
  exp_t exp_q [$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_m = 1;
  int gcnt [2];
  bit mon_off = 1'b0;

  always #5 clk = ~clk;

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_0(req[0]), .req_1(req[1]),
    .we_0(we[0]), .we_1(we[1]),
    .addr_0(addr[0]), .addr_1(addr[1]),
    .wdata_0(wdata[0]), .wdata_1(wdata[1]),
    .gnt_0(gnt_0), .gnt_1(gnt_1),
    .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .rdata_0(rdata_0), .rdata_1(rdata_1),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural single-port RAM, registered read
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", n, a, e);
    end
  endtask

  // Master: present command, hold until gnt seen, then drop req
  task automatic do_cmd(input int p, input logic w,
                        input logic [7:0] a, input logic [7:0] d);
    cmd_t c;
    bit got;
    c.we = w; c.a = a; c.d = d;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    if (p == 0) iss0.push_back(c);
    else iss1.push_back(c);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? gnt_0 : gnt_1;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL gnt_timeout port %0d: got no gnt, required gnt", p);
    end
    req[p] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 &&
         (exp_q.size() != 0 || iss0.size() != 0 || iss1.size() != 0); i++)
      @(negedge clk);
    chk("drain_pending", exp_q.size() + iss0.size() + iss1.size(), 0);
    @(negedge clk);
  endtask

  // Scoreboard monitor: one sample per cycle, away from the edge
  task automatic on_gnt(input int p);
    cmd_t c;
    logic other;
    exp_t e;
    if ((p == 0 && iss0.size() == 0) || (p == 1 && iss1.size() == 0)) begin
      tests++; fails++;
      $display("FAIL unexpected_gnt port %0d: got gnt, required none", p);
      return;
    end
    c = (p == 0) ? iss0.pop_front() : iss1.pop_front();
    tests++;
    if (ram_we !== c.we || ram_addr !== c.a || ram_wdata !== c.d) begin
      fails++;
      $display("FAIL ram_port p%0d: got we=%0b a=%0h d=%0h, required we=%0b a=%0h d=%0h",
               p, ram_we, ram_addr, ram_wdata, c.we, c.a, c.d);
    end
    other = (p == 0) ? req[1] : req[0];
    if (other) begin
      tests++;
      if (p == last_m) begin
        fails++;
        $display("FAIL rr_order: got port %0d, required port %0d", p, 1 - p);
      end
    end
    last_m = p;
    gcnt[p]++;
    if (c.we) shadow[c.a] = c.d;
    else begin
      e.p = p; e.d = shadow[c.a]; e.cyc = cyc;
      exp_q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    logic rv_p;
    logic [7:0] rd_p;
    #2;
    cyc++;
    if (rst) begin
      last_m = 1;
      exp_q.delete();
    end else if (!mon_off) begin
      if (gnt_0 | gnt_1 | rvalid_0 | rvalid_1)
        chk("one_hot", {30'd0, (gnt_0 & gnt_1), (rvalid_0 & rvalid_1)}, 0);
      if (gnt_0) on_gnt(0);
      if (gnt_1) on_gnt(1);
      if (exp_q.size() != 0 && exp_q[0].cyc + 1 == cyc) begin
        e = exp_q.pop_front();
        rv_p = (e.p == 0) ? rvalid_0 : rvalid_1;
        rd_p = (e.p == 0) ? rdata_0 : rdata_1;
        chk($sformatf("rvalid_p%0d", e.p), {31'd0, rv_p}, 1);
        chk($sformatf("rdata_p%0d", e.p), {24'd0, rd_p}, {24'd0, e.d});
      end else if (rvalid_0 | rvalid_1) begin
        tests++; fails++;
        $display("FAIL unexpected_rvalid: got %0b%0b, required 00",
                 rvalid_1, rvalid_0);
      end
    end
  end

  initial begin
    int g0, g1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    gcnt[0] = 0; gcnt[1] = 0;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = 8'h00; wdata[p] = 8'h00;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {30'd0, gnt_1, gnt_0}, 0);
    chk("rst_rvalid", {30'd0, rvalid_1, rvalid_0}, 0);
    chk("rst_ram_we", {31'd0, ram_we}, 0);
    chk("rst_ram_addr", {24'd0, ram_addr}, 0);
    chk("rst_ram_wdata", {24'd0, ram_wdata}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Write then read back from the other port
    do_cmd(0, 1'b1, 8'h04, 8'h12);
    do_cmd(1, 1'b0, 8'h04, 8'h00);
    drain();

    // Simultaneous writes, then readback
    fork
      do_cmd(0, 1'b1, 8'h10, 8'h34);
      do_cmd(1, 1'b1, 8'h11, 8'h56);
    join
    fork
      do_cmd(0, 1'b0, 8'h11, 8'h00);
      do_cmd(1, 1'b0, 8'h10, 8'h00);
    join
    drain();

    // Fairness under continuous read requests
    g0 = gcnt[0]; g1 = gcnt[1];
    fork
      repeat (4) do_cmd(0, 1'b0, 8'($urandom_range(0, 17)), 8'h00);
      repeat (4) do_cmd(1, 1'b0, 8'($urandom_range(0, 17)), 8'h00);
    join
    drain();
    chk("fair_gnt0", gcnt[0] - g0, 4);
    chk("fair_gnt1", gcnt[1] - g1, 4);

    // Reset asserted during CMD of a write
    mon_off = 1'b1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h20; wdata[0] = 8'hAA;
    @(posedge clk);
    #1;
    chk("midrst_gnt_before", {31'd0, gnt_0}, 1);
    chk("midrst_we_before", {31'd0, ram_we}, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_we_after", {31'd0, ram_we}, 0);
    chk("midrst_gnt_after", {31'd0, gnt_0}, 0);
    req[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_off = 1'b0;
    @(negedge clk);
    do_cmd(0, 1'b0, 8'h20, 8'h00);
    drain();

    // Held read on port 1 re-arbitrated against a port 0 write
    g1 = gcnt[1];
    fork
      begin
        do_cmd(1, 1'b0, 8'h04, 8'h00);
        do_cmd(1, 1'b0, 8'h04, 8'h00);
      end
      do_cmd(0, 1'b1, 8'h05, 8'($urandom));
    join
    drain();
    chk("hold_gnt1", gcnt[1] - g1, 2);

    // Randomized traffic from both masters
    fork
      for (int k = 0; k < 40; k++) begin
        do_cmd(0, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      for (int k = 0; k < 40; k++) begin
        do_cmd(1, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
